// File: rtl/muldiv_sequencer.sv
// Arbitrates issue ports onto a shared multi-cycle multiply/divide unit.
// Grants go to the oldest live issue ID, and a flush can kill the op while it is in flight.
module muldiv_sequencer #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  req_issue_id [NUM_PORTS],
  input  logic [1:0]           req_op       [NUM_PORTS],
  input  logic [DATA_W-1:0]    req_a        [NUM_PORTS],
  input  logic [DATA_W-1:0]    req_b        [NUM_PORTS],
  input  logic                 flush,
  input  logic [ID_WIDTH-1:0]  flush_id,
  output logic                 unit_start,
  output logic [1:0]           unit_op,
  output logic [DATA_W-1:0]    unit_a,
  output logic [DATA_W-1:0]    unit_b,
  input  logic                 unit_done,
  input  logic [DATA_W-1:0]    unit_hi,
  input  logic [DATA_W-1:0]    unit_lo,
  output logic [NUM_PORTS-1:0] resp_valid,
  output logic [DATA_W-1:0]    resp_hi,
  output logic [DATA_W-1:0]    resp_lo,
  output logic                 busy
);

  localparam int OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

  state_t              state;
  logic [OWN_W-1:0]    owner;
  logic [ID_WIDTH-1:0] owner_id;
  logic                owner_kill;

  logic                sel_valid;
  logic [OWN_W-1:0]    sel_idx;
  logic [ID_WIDTH-1:0] sel_id;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  // Wrap-aware age: a is older than b when (a - b) lands in the upper half of the ID space.
  function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction

  function automatic logic is_killed(input logic [ID_WIDTH-1:0] id, input logic fl,
                                     input logic [ID_WIDTH-1:0] fid);
    return fl && !older(id, fid);
  endfunction

  // Strict "older" comparison keeps the lowest port index on equal IDs.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !is_killed(req_issue_id[i], flush, flush_id) &&
          (!sel_valid || older(req_issue_id[i], sel_id))) begin
        sel_valid = 1'b1;
        sel_idx   = OWN_W'(i);
        sel_id    = req_issue_id[i];
        sel_op    = req_op[i];
        sel_a     = req_a[i];
        sel_b     = req_b[i];
      end
    end
  end

  assign owner_kill = is_killed(owner_id, flush, flush_id);
  assign busy       = (state != IDLE);

  // A same-cycle flush of the owner masks the response pulse.
  always_comb begin
    resp_valid = '0;
    if (state == RESP && !owner_kill) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        resp_valid[i] = (owner == OWN_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      owner_id   <= '0;
      unit_start <= 1'b0;
      unit_op    <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      resp_hi    <= '0;
      resp_lo    <= '0;
    end else begin
      unit_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner      <= sel_idx;
            owner_id   <= sel_id;
            unit_op    <= sel_op;
            unit_a     <= sel_a;
            unit_b     <= sel_b;
            unit_start <= 1'b1;
            state      <= START;
          end
        end
        START: state <= owner_kill ? DRAIN : WAIT;
        WAIT: begin
          if (owner_kill) begin
            state <= unit_done ? IDLE : DRAIN;
          end else if (unit_done) begin
            resp_hi <= unit_hi;
            resp_lo <= unit_lo;
            state   <= RESP;
          end
        end
        RESP:  state <= IDLE;
        DRAIN: if (unit_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer.
// Grant order and flush outcomes come from an offset-based age model.
module tb_muldiv_sequencer;

  localparam int NP = 3;
  localparam int IW = 4;
  localparam int DW = 32;

  localparam int M_NORM       = 0;
  localparam int M_KILL_START = 1;
  localparam int M_KILL_WAIT  = 2;
  localparam int M_KILL_DONE  = 3;
  localparam int M_KILL_RESP  = 4;
  localparam int M_KEEP       = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] req;
  logic [IW-1:0] req_issue_id [NP];
  logic [1:0]    req_op       [NP];
  logic [DW-1:0] req_a        [NP];
  logic [DW-1:0] req_b        [NP];
  logic          flush;
  logic [IW-1:0] flush_id;
  logic          unit_start;
  logic [1:0]    unit_op;
  logic [DW-1:0] unit_a, unit_b;
  logic          unit_done;
  logic [DW-1:0] unit_hi, unit_lo;
  logic [NP-1:0] resp_valid;
  logic [DW-1:0] resp_hi, resp_lo;
  logic          busy;

  muldiv_sequencer #(.NUM_PORTS(NP), .ID_WIDTH(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .flush_id(flush_id),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo),
    .resp_valid(resp_valid), .resp_hi(resp_hi), .resp_lo(resp_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: IDs are base + small offset, so age is plain offset order.
  int            base;
  int            off  [NP];
  bit            pend [NP];
  logic [DW-1:0] last_hi, last_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick();
    int best = -1;
    for (int p = 0; p < NP; p++)
      if (pend[p] && (best < 0 || off[p] < off[best])) best = p;
    return best;
  endfunction

  task automatic set_req(input int p, input int o, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    off[p] = o;
    pend[p] = 1'b1;
    req[p] = 1'b1;
    req_issue_id[p] = IW'(base + o);
    req_op[p] = op;
    req_a[p] = a;
    req_b[p] = b;
  endtask

  // Killed requesters drop req, as a real issue stage would.
  task automatic flush_now(input int fo);
    flush = 1'b1;
    flush_id = IW'(base + fo);
    for (int p = 0; p < NP; p++)
      if (pend[p] && off[p] >= fo) begin
        pend[p] = 1'b0;
        req[p] = 1'b0;
      end
  endtask

  task automatic serve_one(input int mode, input int fo, input int d,
                           input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    int            own;
    bit            kill;
    logic [1:0]    eop;
    logic [DW-1:0] ea, eb;
    own = pick();
    eop = req_op[own];
    ea  = req_a[own];
    eb  = req_b[own];
    kill = (mode == M_KILL_START || mode == M_KILL_WAIT || mode == M_KILL_DONE);
    check("idle_busy", busy, 0);
    tick();
    check("start", unit_start, 1);
    check("unit_op", unit_op, eop);
    check("unit_a", unit_a, ea);
    check("unit_b", unit_b, eb);
    check("start_busy", busy, 1);
    check("start_resp", resp_valid, 0);
    if (mode == M_KILL_START) flush_now(fo);
    tick();
    flush = 1'b0;
    for (int k = 0; k < d; k++) begin
      check("wait_start", unit_start, 0);
      check("wait_busy", busy, 1);
      check("wait_resp", resp_valid, 0);
      if (k == 0 && (mode == M_KILL_WAIT || mode == M_KEEP)) flush_now(fo);
      tick();
      flush = 1'b0;
    end
    unit_done = 1'b1;
    unit_hi = hi;
    unit_lo = lo;
    if (mode == M_KILL_DONE) flush_now(fo);
    tick();
    unit_done = 1'b0;
    flush = 1'b0;
    if (kill) begin
      check("kill_busy", busy, 0);
      check("kill_resp", resp_valid, 0);
      check("kill_hi", resp_hi, last_hi);
      check("kill_lo", resp_lo, last_lo);
    end else begin
      check("resp_valid", resp_valid, 64'(1) << own);
      check("resp_hi", resp_hi, hi);
      check("resp_lo", resp_lo, lo);
      check("resp_busy", busy, 1);
      check("resp_start", unit_start, 0);
      last_hi = hi;
      last_lo = lo;
      pend[own] = 1'b0;
      req[own] = 1'b0;
      if (mode == M_KILL_RESP) begin
        flush_now(fo);
        #1;
        check("resp_masked", resp_valid, 0);
      end
      tick();
      flush = 1'b0;
      check("after_busy", busy, 0);
      check("after_resp", resp_valid, 0);
    end
    check("hold_a", unit_a, ea);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int own, mode, fo;
    bit any;
    rst_n = 1'b0;
    req = '0;
    flush = 1'b0;
    flush_id = '0;
    unit_done = 1'b0;
    unit_hi = '0;
    unit_lo = '0;
    last_hi = '0;
    last_lo = '0;
    base = 0;
    for (int p = 0; p < NP; p++) begin
      req_issue_id[p] = '0;
      req_op[p] = '0;
      req_a[p] = '0;
      req_b[p] = '0;
      off[p] = 0;
      pend[p] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", unit_start, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_a", unit_a, 0);
    check("rst_hi", resp_hi, 0);
    rst_n = 1'b1;
    tick();

    // ID 5, a=7 b=3, done four cycles after start, hi=1 lo=2
    base = 5;
    set_req(0, 0, 2'd1, 32'd7, 32'd3);
    serve_one(M_NORM, 0, 3, 32'd1, 32'd2);

    // IDs 14 and 1: 14 is older across the wrap
    base = 14;
    set_req(0, 0, 2'd2, 32'hA0, 32'hB0);
    set_req(1, 3, 2'd3, 32'hA1, 32'hB1);
    serve_one(M_NORM, 0, 2, 32'h11, 32'h22);
    serve_one(M_NORM, 0, 2, 32'h33, 32'h44);

    // Equal IDs: lowest port wins
    base = 3;
    set_req(0, 0, 2'd0, 32'hC0, 32'hD0);
    set_req(1, 0, 2'd1, 32'hC1, 32'hD1);
    serve_one(M_NORM, 0, 1, 32'h55, 32'h66);
    serve_one(M_NORM, 0, 1, 32'h77, 32'h88);

    // Owner ID 6: flush_id 5 kills it, flush_id 7 does not
    base = 5;
    set_req(0, 1, 2'd2, 32'h1234, 32'h5678);
    serve_one(M_KILL_WAIT, 0, 2, 32'hDEAD, 32'hBEEF);
    set_req(0, 1, 2'd2, 32'h1234, 32'h5678);
    serve_one(M_KEEP, 2, 2, 32'h99, 32'hAA);

    // Flush coinciding with done, then flush during the response cycle
    set_req(0, 1, 2'd1, 32'h42, 32'h43);
    serve_one(M_KILL_DONE, 1, 2, 32'hF0, 32'hF1);
    set_req(0, 1, 2'd1, 32'h44, 32'h45);
    serve_one(M_KILL_RESP, 1, 2, 32'hF2, 32'hF3);

    for (int iter = 0; iter < 40; iter++) begin
      base = int'($urandom_range(0, 15));
      any = 1'b0;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) != 0) begin
          set_req(p, int'($urandom_range(0, 6)), 2'($urandom), $urandom, $urandom);
          any = 1'b1;
        end
      if (!any) set_req(0, int'($urandom_range(0, 6)), 2'($urandom), $urandom, $urandom);
      while (pick() >= 0) begin
        own  = pick();
        mode = int'($urandom_range(0, 5));
        if (mode == M_KEEP) fo = off[own] + 1;
        else if (mode == M_NORM) fo = 0;
        else fo = int'($urandom_range(0, off[own]));
        serve_one(mode, fo, int'($urandom_range(1, 4)), $urandom, $urandom);
      end
    end

    // Reset while waiting on the unit; a late done must be ignored
    base = 2;
    set_req(0, 0, 2'd3, 32'h77, 32'h66);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", unit_start, 0);
    check("mid_rst_resp", resp_valid, 0);
    check("mid_rst_op", unit_op, 0);
    check("mid_rst_a", unit_a, 0);
    check("mid_rst_b", unit_b, 0);
    check("mid_rst_hi", resp_hi, 0);
    check("mid_rst_lo", resp_lo, 0);
    pend[0] = 1'b0;
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    unit_done = 1'b1;
    unit_hi = 32'h5;
    unit_lo = 32'h6;
    tick();
    unit_done = 1'b0;
    check("late_done_resp", resp_valid, 0);
    check("late_done_busy", busy, 0);
    tick();
    check("late_done_resp2", resp_valid, 0);
    check("late_done_busy2", busy, 0);
    check("late_done_hi", resp_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting issue ports.
REQ-002 Parameter ID_WIDTH, default 4: issue-ID width; IDs wrap modulo 2^ID_WIDTH.
REQ-003 Parameter DATA_W, default 32: operand and result width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req[NUM_PORTS]  input  1  port requests the multiply/divide unit; held until resp_valid or flush.
REQ-007 req_issue_id[NUM_PORTS]  input  ID_WIDTH  issue ID of the requesting instruction.
REQ-008 req_op[NUM_PORTS]  input  2  operation code, passed to the unit unchanged.
REQ-009 req_a[NUM_PORTS], req_b[NUM_PORTS]  input  DATA_W  operands.
REQ-010 flush  input  1  kill request; flush_id  input  ID_WIDTH  oldest ID being killed.
REQ-011 unit_start  output  1  one-cycle start pulse to the unit; unit_op  output 2; unit_a, unit_b  output  DATA_W.
REQ-012 unit_done  input  1  unit result valid, one cycle; unit_hi, unit_lo  input  DATA_W.
REQ-013 resp_valid[NUM_PORTS]  output  1  result pulse to owning port; resp_hi, resp_lo  output  DATA_W.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 State machine SHALL have states IDLE, START, WAIT, RESP, DRAIN.
REQ-016 Age compare: a older than b iff bit ID_WIDTH-1 of (a - b) mod 2^ID_WIDTH is 1.
REQ-017 A request is killed iff flush=1 and its ID is not older than flush_id (equal counts as killed).
REQ-018 IDLE: among live, non-killed requests, select the oldest ID; ties go to the lowest port index; latch owner index, ID, op and operands; go to START next cycle.
REQ-019 IDLE with no eligible request: remain IDLE, all outputs idle.
REQ-020 START: unit_start=1 for exactly one cycle, with unit_op/unit_a/unit_b driven from latched values; next state WAIT (DRAIN if the owner is killed this cycle).
REQ-021 unit_a, unit_b and unit_op SHALL hold the latched values from START until the next selection; they are zero after reset.
REQ-022 WAIT: on unit_done, capture unit_hi/unit_lo and go to RESP; no timeout.
REQ-023 WAIT with the owner killed: go to DRAIN; if unit_done arrives in the same cycle, discard the result and go to IDLE.
REQ-024 RESP: resp_valid[owner]=1 for exactly one cycle with the captured resp_hi/resp_lo; go to IDLE next cycle.
REQ-025 RESP with the owner killed in the same cycle: resp_valid is suppressed (combinationally masked); go to IDLE.
REQ-026 DRAIN: wait for unit_done, discard the result, go to IDLE; flush has no further effect.
REQ-027 A new selection SHALL NOT occur in the cycle the FSM returns to IDLE; the earliest re-grant is the first cycle spent in IDLE. The owning port must drop req after resp_valid.
REQ-028 resp_hi/resp_lo hold their value until the next capture.
REQ-029 At most one resp_valid bit is high in any cycle; unit_start never occurs outside START.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, clear the owner and all latches, and drive unit_start, resp_valid, busy, unit_*, resp_hi and resp_lo to 0.
REQ-031 Reset mid-operation abandons the in-flight op; a later unit_done in IDLE is ignored.

Verification
REQ-032 Port0 ID=5 a=7 b=3, unit_done 4 cycles after start, hi=1 lo=2 -> unit_start at cycle 2; resp_valid[0] with hi=1 lo=2 one cycle after unit_done; busy low one cycle later.
REQ-033 Port0 ID=14, port1 ID=1 (ID_WIDTH=4) in the same cycle -> port0 is granted (wrap-aware: 14 is older); port1 served immediately after port0's response.
REQ-034 Port0 and port1 both with ID=3 -> port0 is granted.
REQ-035 Flush with flush_id=5 while the owner ID=6 is in WAIT -> DRAIN; unit_done is discarded, no resp_valid; IDLE after done. Flush with flush_id=7 on the same op -> normal response.
REQ-036 Flush coinciding with unit_done, and flush in RESP -> no resp_valid, IDLE next cycle.
REQ-037 rst_n asserted during WAIT, then unit_done pulsed after release -> all outputs 0, no resp_valid, busy 0.
